// File: rtl/unpack_bus_words_pkg.sv
// Shared definitions for the 64-bit word to W-bit element unpacker.
// Holds the bus width, FSM state type and the word-count helper.
package unpack_bus_words_pkg;

    localparam int BUS_W = 64;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ceil(n / 2^lg) with one spare bit, so n = all-ones cannot wrap.
    function automatic logic [32:0] ceil_div_pow2(input logic [31:0] n, input int unsigned lg);
        logic [32:0] sum;
        sum = {1'b0, n} + ((33'd1 << lg) - 33'd1);
        return sum >> lg;
    endfunction

endpackage

// File: rtl/unpack_bus_words_lane_shifter.sv
// Holds the current 64-bit word and its count of unread lanes.
// A load beats a flush, and a flush beats a shift.
module lane_shifter
    import unpack_bus_words_pkg::*;
#(
    parameter int W      = 16,
    parameter int LANE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BUS_W-1:0]  load_word,
    input  logic              shift,
    input  logic              flush,
    output logic [W-1:0]      word_lo,
    output logic [LANE_W-1:0] lanes
);

    localparam int R = BUS_W / W;

    logic [BUS_W-1:0] word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word  <= '0;
            lanes <= '0;
        end else if (load) begin
            word  <= load_word;
            lanes <= LANE_W'(R);
        end else if (flush) begin
            lanes <= '0;
        end else if (shift) begin
            word  <= word >> W;
            lanes <= lanes - 1'b1;
        end
    end

    assign word_lo = word[W-1:0];

endmodule

// File: rtl/unpack_bus_words.sv
// Splits 64-bit serdes words into W-bit elements, low lane first, and emits
// exactly the commanded element count; padding lanes of the final word are dropped.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// isReady and the consumer's canReceive are both 1. in_canReceive may depend
// on out_canReceive within the cycle, never on in_isReady.
module unpack_bus_words
    import unpack_bus_words_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [CNT_W-1:0]  cmd_numElems,
    output logic              cmd_canReceive,
    output logic              done,
    input  logic [BUS_W-1:0]  in,
    input  logic              in_isReady,
    output logic              in_canReceive,
    input  logic              in_isLast,
    output logic [W-1:0]      out,
    output logic              out_isReady,
    input  logic              out_canReceive,
    output logic              out_isLast,
    output logic              err_lastMismatch,
    output state_t            dbg_state
);

    localparam int          R      = BUS_W / W;
    localparam int unsigned LG     = $clog2(R);
    localparam int          LANE_W = $clog2(R + 1);

    state_t             state;
    logic [CNT_W-1:0]   elems_left;
    logic [CNT_W-1:0]   words_left;
    logic [CNT_W-1:0]   words_init;
    logic               done_r;
    logic               err_r;
    logic [LANE_W-1:0]  lanes;
    logic [W-1:0]       word_lo;
    logic               run;
    logic               out_xfer;
    logic               in_xfer;
    logic               last_xfer;

    assign run        = (state == S_RUN);
    assign words_init = CNT_W'(ceil_div_pow2(32'(cmd_numElems), LG));

    assign out_isReady = run && (lanes != '0);
    assign out_isLast  = out_isReady && (elems_left == CNT_W'(1));
    assign out_xfer    = out_isReady && out_canReceive;
    assign last_xfer   = out_xfer && out_isLast;

    // The next word may land in the same cycle the last lane leaves.
    assign in_canReceive = run && (words_left != '0) &&
                           ((lanes == '0) || ((lanes == LANE_W'(1)) && out_xfer));
    assign in_xfer       = in_isReady && in_canReceive;

    assign cmd_canReceive   = (state == S_IDLE);
    assign done             = done_r;
    assign err_lastMismatch = err_r;
    assign out              = word_lo;
    assign dbg_state        = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            elems_left <= '0;
            words_left <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        err_r <= 1'b0;
                        if (cmd_numElems == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            elems_left <= cmd_numElems;
                            words_left <= words_init;
                        end
                    end
                end
                S_RUN: begin
                    if (in_xfer) begin
                        words_left <= words_left - 1'b1;
                        // Flag only; the counters still decide when the job ends.
                        if (in_isLast != (words_left == CNT_W'(1)))
                            err_r <= 1'b1;
                    end
                    if (out_xfer)
                        elems_left <= elems_left - 1'b1;
                    if (last_xfer) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    lane_shifter #(
        .W      (W),
        .LANE_W (LANE_W)
    ) u_lane_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (in_xfer),
        .load_word (in),
        .shift     (out_xfer),
        .flush     (last_xfer),
        .word_lo   (word_lo),
        .lanes     (lanes)
    );

endmodule

// File: doc/unpack_bus_words.md
# unpack_bus_words

Width-converting stage directly downstream of the 64-bit `serdes` serializer port. It accepts 64-bit words on the `isReady`/`canReceive`/`isLast` stream, splits each word into 64/W elements (low bits first), and emits exactly the commanded number of W-bit elements to the arithmetic datapath. Trailing padding lanes of the final word are discarded.

## Interface
- `W`, 16: element width; must divide 64. R = 64/W lanes per word.
- `CNT_W`, 16: width of the element count.
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `cmd_start`  input  1  start a job; taken only when `cmd_canReceive`=1.
- `cmd_numElems`  input  CNT_W  number of elements to emit; sampled with `cmd_start`.
- `cmd_canReceive`  output  1  block idle; a job may start.
- `done`  output  1  one-cycle pulse when a job completes.
- `in`  input  64  packed word; lane 0 is `in[W-1:0]`.
- `in_isReady`  input  1  upstream word valid.
- `in_canReceive`  output  1  block takes the word this cycle.
- `in_isLast`  input  1  upstream marks its final word.
- `out`  output  W  current element.
- `out_isReady`  output  1  `out` is valid.
- `out_canReceive`  input  1  downstream accepts the element.
- `out_isLast`  output  1  current element is the job's last.
- `err_lastMismatch`  output  1  sticky; cleared by the next accepted `cmd_start`.

## Operation
- State: IDLE / RUN, plus these registers:
  - `word`: 64-bit shift register.
  - `lanes`: valid lanes in `word`, 0..R.
  - `elemsLeft`: elements still to emit (CNT_W bits).
  - `wordsLeft`: words still to take, ceil(numElems/R) computed at start.
- Reset values: IDLE, all registers 0.
  - `cmd_canReceive`=1.
  - `in_canReceive`=0, `out_isReady`=0, `out_isLast`=0.
  - `done`=0, `err_lastMismatch`=0.
  - `out`=0.
- IDLE → RUN when `cmd_start` is accepted with `numElems`>0. Load the counters and clear the error flag.
- `cmd_start` with `numElems`=0: stay IDLE, pulse `done` next cycle, no transfers.
- `cmd_start` while in RUN is ignored.
- `out` = `word[W-1:0]`. `out_isReady` = RUN and `lanes`≠0. `out_isLast` = `out_isReady` and `elemsLeft`==1.
- Output transfer (`out_isReady`&`out_canReceive`): shift `word` right by W, `lanes`−1, `elemsLeft`−1.
- `in_canReceive` = RUN & `wordsLeft`≠0 & (`lanes`==0 | (`lanes`==1 & output transfer this cycle)).
  - Depends combinationally on `out_canReceive`. This path is allowed; there is no path from `in_isReady`.
- Input transfer (`in_isReady`&`in_canReceive`): load `word`=`in`, `lanes`=R, `wordsLeft`−1.
  - This wins over the shift when both happen in the same cycle.
- When the transfer with `out_isLast` completes:
  - Set `lanes`=0, discarding padding lanes.
  - Go to IDLE; `done` pulses in the following cycle.
- `err_lastMismatch` is set when either occurs:
  - An accepted word has `in_isLast`≠(`wordsLeft`==1).
  - The mismatch flag has no effect on flow; the counters alone govern the job.
- Width rule: `numElems` up to 2^CNT_W−1. `wordsLeft` is CNT_W bits and is computed as (`numElems`+R−1)>>log2(R) without overflow, using a CNT_W+1 intermediate.

## Timing
- The input word is visible on `out` one cycle after the input transfer. Registered; no combinational `in`→`out` path.
- Sustained throughput: one element per cycle with no bubble at word boundaries. The next word loads in the same cycle as the last lane is consumed.
- `cmd_canReceive` returns to 1 in the cycle after the final output transfer, the same cycle as `done`.
- Back-to-back jobs: a new `cmd_start` is accepted in the `done` cycle.
- Downstream stall: all state holds and `in_canReceive` stays 0 while `lanes`>1.
- Reset asserted mid-job: all state is cleared immediately, asynchronously. Any partial word is lost and no `done` is produced.

## Structure
- Shared include: `BUS_W`=64, handshake port naming, and the ceil-divide helper constant function used for `wordsLeft`.
- One sub-module, `lane_shifter`: holds `word`/`lanes` and handles load, shift and flush. The top level holds the FSM, the counters and the error flag.
- Its registers use async active-low reset, as this block does.

## Test plan
- W=16, numElems=8, two words 0x0004_0003_0002_0001 and 0x0008_..._0005, sink always ready → `out` = 1..8 on consecutive cycles. `out_isLast` only on 8; `done` 1 cycle later; err=0.
- numElems=5, words as above → emits 1..5, then `done`. Lanes 6..8 are discarded; only 2 words are taken.
- Same 8-element job with `out_canReceive` toggling 1,0,0,1… → order is preserved, no duplicates, `in_canReceive` is never high while `lanes`>1.
- numElems=0 → `done` pulses 1 cycle after `cmd_start`; `in_canReceive` stays 0.
- numElems=8 with `in_isLast`=1 on the first word → err=1 and all 8 elements are still emitted. The next `cmd_start` clears err.
- Assert `rst` low after 3 elements of an 8-element job → outputs hold reset values immediately. A fresh job then runs cleanly.
